// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, oversampled bit recovery with
// a three-sample majority vote, optional parity check and stop-bit check.
// A good byte is presented on P_DATA with a one-cycle DATA_VALID pulse;
// parity and stop errors are reported as one-cycle pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] SAMP_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SAMP_A    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP_B    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SAMP_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic                  rx_m;
  logic                  rx_s;
  logic [CW-1:0]         samp_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  samp_a;
  logic                  samp_b;
  logic                  armed;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_mis;
  logic [DATA_WIDTH-1:0] shreg;

  logic at_dec;
  logic at_wrap;
  logic vote;
  logic start_det;
  logic shift_en;
  logic par_chk;
  logic frame_end;

  assign at_dec  = (samp_cnt == SAMP_DEC);
  assign at_wrap = (samp_cnt == SAMP_LAST);
  // Majority of the two stored centre samples and the current one.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_IN;
      rx_s <= rx_m;
    end
  end

  // Frame state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && armed) begin
          start_det  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (at_dec && vote) begin
          state_next = IDLE;
        end else if (at_wrap) begin
          state_next = DATA;
        end
      end
      DATA: begin
        shift_en = at_dec;
        if (at_wrap && (bit_cnt == BIT_LAST)) begin
          state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk = at_dec;
        if (at_wrap) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (at_dec) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample and bit counters plus the two stored centre samples.
  // bit_cnt advances at the bit wrap rather than the decision point; the
  // last-bit test at the wrap sees the same count either way.
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else begin
      if (state_next == IDLE) begin
        samp_cnt <= '0;
      end else if (at_wrap) begin
        samp_cnt <= '0;
      end else begin
        samp_cnt <= samp_cnt + CW'(1);
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (at_wrap) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end

      if (samp_cnt == SAMP_A) begin
        samp_a <= rx_s;
      end
      if (samp_cnt == SAMP_B) begin
        samp_b <= rx_s;
      end
    end
  end

  // Frame datapath: config latch, shift register, parity/stop evaluation,
  // break re-arming and the registered result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed      <= 1'b1;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_mis    <= 1'b0;
      shreg      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BUSY       <= (state_next != IDLE);

      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_mis   <= 1'b0;
      end

      if (shift_en) begin
        shreg <= {vote, shreg[DATA_WIDTH-1:1]};
      end

      if (par_chk) begin
        par_mis <= (vote != ((^shreg) ^ par_typ_q));
      end

      if (frame_end) begin
        if (vote && !par_mis) begin
          P_DATA     <= shreg;
          DATA_VALID <= 1'b1;
        end
        PAR_ERR <= par_mis;
        STP_ERR <= ~vote;
        if (!vote) begin
          armed <= 1'b0;
        end
      end

      // A low line after a stop error must return high before a new start.
      if ((state == IDLE) && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (8 data bits, 8 samples per bit).
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dv_cyc = 0;
  int frame_c = 0;
  logic [7:0] dv_q[$];

  uart_rx #(
    .DATA_WIDTH(8),
    .OVERSAMPLE(8)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
      dv_q.push_back(p_data);
    end
    if (par_err) pe_cnt = pe_cnt + 1;
    if (stp_err) se_cnt = se_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  // glitch[i] flips data bit i for one sample at the bit centre.
  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                            input logic stop_bit, input logic [7:0] glitch);
    frame_c = cyc;
    drive(1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      if (glitch[i]) begin
        drive(d[i], 4);
        drive(~d[i], 1);
        drive(d[i], 3);
      end else begin
        drive(d[i], 8);
      end
    end
    if (with_par) drive(par_bit, 8);
    drive(stop_bit, 8);
  endtask

  initial begin
    int dv0, pe0, se0, c0;
    logic [7:0] first, second;

    rst = 1'b1;
    rx_in = 1'b1;
    par_en = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_p_data", p_data, 8'h00);
    check_eq("rst_dv", data_valid, 1'b0);
    check_eq("rst_pe", par_err, 1'b0);
    check_eq("rst_se", stp_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive(1'b1, 5);

    // Plain frame, latency check
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("a5_dv_cnt", dv_cnt - dv0, 1);
    check_eq("a5_latency", dv_cyc - frame_c, 80);
    check_eq("a5_p_data", p_data, 8'hA5);
    check_eq("a5_pe_cnt", pe_cnt - pe0, 0);
    check_eq("a5_se_cnt", se_cnt - se0, 0);
    check_eq("a5_busy", busy, 1'b0);

    // Even parity, correct parity bit
    par_en = 1'b1; par_typ = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("par_ok_dv_cnt", dv_cnt - dv0, 1);
    check_eq("par_ok_latency", dv_cyc - frame_c, 88);
    check_eq("par_ok_p_data", p_data, 8'h07);
    check_eq("par_ok_pe_cnt", pe_cnt - pe0, 0);

    // Even parity, wrong parity bit
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("par_bad_dv_cnt", dv_cnt - dv0, 0);
    check_eq("par_bad_pe_cnt", pe_cnt - pe0, 1);
    check_eq("par_bad_se_cnt", se_cnt - se0, 0);
    check_eq("par_bad_p_data", p_data, 8'h07);

    // Odd parity, 0x5B has five ones so parity bit 0 is correct
    par_typ = 1'b1;
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h5B, 1'b1, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("odd_dv_cnt", dv_cnt - dv0, 1);
    check_eq("odd_p_data", p_data, 8'h5B);
    check_eq("odd_pe_cnt", pe_cnt - pe0, 0);
    par_en = 1'b0; par_typ = 1'b0;

    // Stop bit low, then a held break
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 100);
    check_eq("stp_se_cnt", se_cnt - se0, 1);
    check_eq("stp_dv_cnt", dv_cnt - dv0, 0);
    check_eq("stp_pe_cnt", pe_cnt - pe0, 0);
    check_eq("brk_busy", busy, 1'b0);
    check_eq("stp_p_data", p_data, 8'h5B);
    drive(1'b1, 10);
    dv0 = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("post_brk_dv_cnt", dv_cnt - dv0, 1);
    check_eq("post_brk_p_data", p_data, 8'h55);

    // Two-cycle glitch on an idle line
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    drive(1'b0, 2);
    drive(1'b1, 2);
    check_eq("glitch_busy_hi", busy, 1'b1);
    drive(1'b1, 12);
    check_eq("glitch_busy_lo", busy, 1'b0);
    check_eq("glitch_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

    // Single-sample glitches at bit centres
    dv0 = dv_cnt;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 8'h0F);
    drive(1'b1, 4);
    check_eq("vote_dv_cnt", dv_cnt - dv0, 1);
    check_eq("vote_p_data", p_data, 8'h96);

    // Back-to-back frames with no idle gap
    dv0 = dv_cnt;
    dv_q.delete();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 8'h00);
    c0 = frame_c;
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    first = (dv_q.size() > 0) ? dv_q[0] : 8'hxx;
    second = (dv_q.size() > 1) ? dv_q[1] : 8'hxx;
    check_eq("b2b_dv_cnt", dv_cnt - dv0, 2);
    check_eq("b2b_first", first, 8'h01);
    check_eq("b2b_second", second, 8'hFE);
    check_eq("b2b_gap", frame_c - c0, 80);
    check_eq("b2b_last_latency", dv_cyc - frame_c, 80);

    // Reset mid-data of 0x99 (start + bits 0..2 partially sent)
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    drive(1'b0, 8);
    drive(1'b1, 8);
    drive(1'b0, 8);
    drive(1'b0, 4);
    rst = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_p_data", p_data, 8'h00);
    rst = 1'b0;
    drive(1'b1, 20);
    check_eq("mid_rst_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 4);
    check_eq("after_rst_dv_cnt", dv_cnt - dv0, 1);
    check_eq("after_rst_p_data", p_data, 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that sits directly downstream of the UART transmitter and consumes its serial TX_OUT line.
- Oversamples RX_IN, recovers start/data/optional parity/stop bits and checks parity and stop.
- Presents each good byte as a one-cycle DATA_VALID pulse with P_DATA.
- Parity configuration matches the transmitter's: PAR_EN enables, PAR_TYP 0 = even, 1 = odd.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
OVERSAMPLE, 8, CLK cycles per bit; must be even and >= 6.

Ports:
CLK  input  1  clock; one CLK cycle is one sample.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line, idle high; asynchronous to CLK.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last good received byte.
DATA_VALID  output  1  one-cycle pulse: P_DATA updated with a good frame.
PAR_ERR  output  1  one-cycle pulse: parity mismatch.
STP_ERR  output  1  one-cycle pulse: stop bit sampled low.
BUSY  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset: all of the following take effect on the next CLK edge, mid-frame included (the partial frame is discarded, no pulses are generated):
  - state = IDLE; armed = 1; counters = 0.
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR, BUSY = 0.
  - synchroniser flops = 1.
- Input sync: RX_IN passes through two flops to give rx_s; all logic below uses rx_s only.
- Counters:
  - samp_cnt runs 0..OVERSAMPLE-1 and wraps once per bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Bit value: majority of the rx_s samples at samp_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The value is decided at samp_cnt = OVERSAMPLE/2+1 (the "decision point").
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on the first cycle with rx_s = 0 and armed = 1. samp_cnt = 0 on that cycle. PAR_EN and PAR_TYP are latched on this cycle; mid-frame changes are ignored.
  - START:
    - Decision = 1: false start (glitch); return to IDLE, no pulse.
    - Decision = 0: advance to DATA at the samp_cnt wrap.
  - DATA: at each decision point, shift the bit into the shift register LSB-first and advance bit_cnt. At the wrap after bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN = 1, else to STOP.
  - PARITY: at the decision point compute expected = XOR(data) XOR PAR_TYP and store mismatch. Go to STOP at the wrap.
  - STOP: at the decision point evaluate the frame and go to IDLE immediately, without waiting for the bit to finish. This allows back-to-back frames.
- Frame evaluation happens at the stop decision point; the outputs below register one cycle later, so the pulses land on the cycle after the decision point:
  - Stop = 1 and no parity mismatch: P_DATA <= shift register, DATA_VALID = 1.
  - Parity mismatch: PAR_ERR = 1; P_DATA is held; no DATA_VALID.
  - Stop = 0: STP_ERR = 1; P_DATA is held; no DATA_VALID; armed = 0.
  - Parity mismatch and stop = 0 together: PAR_ERR and STP_ERR both pulse on the same cycle.
- Break handling: armed returns to 1 on the first IDLE cycle with rx_s = 1. A line held low therefore yields exactly one STP_ERR, not repeated frames.
- Latency example (OVERSAMPLE=8, PAR_EN=0, start edge detected at cycle t0): the stop decision point is at t0+77 and DATA_VALID is high at t0+78. rx_s lags RX_IN by 2 cycles.
- BUSY is registered: high from the cycle after start detect until IDLE is re-entered.

Test Plan:
- Reset, RX_IN idle high -> all outputs 0, BUSY 0. Frame 0xA5, PAR_EN=0, 8 cycles/bit -> DATA_VALID one cycle at t0+78, P_DATA=0xA5, no error pulses.
- PAR_EN=1, PAR_TYP=0, byte 0x07 with parity bit 1 -> DATA_VALID, P_DATA=0x07. Same byte with parity bit 0 -> PAR_ERR pulse only, P_DATA stays 0x07.
- Stop bit driven low on byte 0x3C -> STP_ERR pulse, no DATA_VALID. Then hold RX_IN low 100 cycles -> no further pulses, BUSY returns 0. Release high, send 0x55 -> DATA_VALID, P_DATA=0x55.
- 2-cycle low glitch on idle line -> BUSY rises then falls within one bit, no pulses. Single-sample glitch at data-bit centre -> majority vote keeps the correct bit.
- Back-to-back frames 0x01, 0xFE with no idle gap -> two DATA_VALID pulses, P_DATA 0x01 then 0xFE.
- RST asserted mid-data of frame 0x99 -> next cycle BUSY=0, no pulses. The following clean frame 0x42 -> DATA_VALID, P_DATA=0x42.
